// File: rtl/slice_rd_sched.sv
`default_nettype none
// =====================================================================
// slice_rd_sched : raster-order read scheduler for per-slice sync buffers
// Optional: SLICE_RD_SCHED_STALL_CNT_EN builds the starvation counter.
// Rev 1.0
// =====================================================================
module slice_rd_sched #(
  parameter int MAX_NBR_SLICES   = 2,
  parameter int MAX_SLICE_WIDTH  = 2560,
  parameter int MAX_SLICE_HEIGHT = 2560
) (
  input  logic                               clk_out_int,
  input  logic                               rst_n,
  input  logic                               flush,
  input  logic                               start,
  input  logic [9:0]                         slices_per_line,
  input  logic [$clog2(MAX_SLICE_WIDTH)-1:0] slice_width,
  input  logic [15:0]                        frame_height,
  input  logic [MAX_NBR_SLICES-1:0]          fifo_empty,
  input  logic                               out_ready,
  output logic [MAX_NBR_SLICES-1:0]          rd_en,
  output logic [$clog2(MAX_NBR_SLICES)-1:0]  rd_sel,
  output logic                               rd_last_chunk,
  output logic                               rd_last_line,
  output logic                               rd_last_frame,
  output logic                               busy,
  output logic [15:0]                        stall_cnt
);

  localparam int SEL_W  = $clog2(MAX_NBR_SLICES);
  localparam int UNIT_W = $clog2(MAX_SLICE_WIDTH / 4 + 1);

  generate
    if (MAX_NBR_SLICES < 2 || (MAX_SLICE_WIDTH % 4) != 0 || MAX_SLICE_HEIGHT > 65535) begin : g_bad_params
      $error("slice_rd_sched: illegal parameter set");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state, state_nx;
  logic [SEL_W-1:0]  sel_nx;
  logic [UNIT_W-1:0] unit_cnt, unit_nx;
  logic [15:0]       line_cnt, line_nx;
  logic [31:0]       units, spl_eff, fh_eff;
  logic              go, chunk_end, sel_wrap, frame_end;

  // Degenerate configuration values are folded into their legal equivalents.
  always_comb begin
    units = 32'(slice_width) >> 2;
    if (units == 32'd0) units = 32'd1;
    spl_eff = 32'(slices_per_line);
    if (spl_eff == 32'd0)
      spl_eff = 32'd1;
    else if (spl_eff > 32'(MAX_NBR_SLICES))
      spl_eff = 32'(MAX_NBR_SLICES);
    fh_eff = 32'(frame_height);
    if (fh_eff == 32'd0) fh_eff = 32'd1;
  end

  assign chunk_end = (32'(unit_cnt) == units - 32'd1);
  assign sel_wrap  = (32'(rd_sel) >= spl_eff - 32'd1);
  assign frame_end = (32'(line_cnt) == fh_eff - 32'd1);

  // A restart or abort in the same cycle suppresses the read.
  assign go = (state == READ) & ~flush & ~start & ~fifo_empty[rd_sel] & out_ready;

  always_comb begin
    rd_en         = '0;
    rd_en[rd_sel] = go;
  end

  assign rd_last_chunk = go & chunk_end;
  assign rd_last_line  = rd_last_chunk & sel_wrap;
  assign rd_last_frame = rd_last_line & frame_end;
  assign busy          = (state == READ);

  always_comb begin
    state_nx = state;
    sel_nx   = rd_sel;
    unit_nx  = unit_cnt;
    line_nx  = line_cnt;
    if (flush) begin
      state_nx = IDLE;
    end else if (start) begin
      state_nx = READ;
      sel_nx   = '0;
      unit_nx  = '0;
      line_nx  = '0;
    end else begin
      case (state)
        IDLE: state_nx = IDLE;
        READ: begin
          if (go) begin
            if (chunk_end) begin
              unit_nx = '0;
              if (sel_wrap) begin
                sel_nx  = '0;
                line_nx = line_cnt + 16'd1;
                if (frame_end) state_nx = DONE;
              end else begin
                sel_nx = rd_sel + SEL_W'(1);
              end
            end else begin
              unit_nx = unit_cnt + UNIT_W'(1);
            end
          end
        end
        DONE:    state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_out_int or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rd_sel   <= '0;
      unit_cnt <= '0;
      line_cnt <= '0;
    end else begin
      state    <= state_nx;
      rd_sel   <= sel_nx;
      unit_cnt <= unit_nx;
      line_cnt <= line_nx;
    end
  end

`ifdef SLICE_RD_SCHED_STALL_CNT_EN
  // Counts input starvation only; back-pressure from out_ready is not a stall.
  always_ff @(posedge clk_out_int or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (start & ~flush)
      stall_cnt <= '0;
    else if (busy & out_ready & fifo_empty[rd_sel] & (stall_cnt != 16'hFFFF))
      stall_cnt <= stall_cnt + 16'd1;
  end
`else
  assign stall_cnt = '0;
`endif

endmodule
`default_nettype wire
